// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the inverse round datapath.
// Latency: none; every function here is pure combinational logic.
// Backpressure: not applicable.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  // Low byte of the reduction polynomial x^8+x^4+x^3+x+1.
  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // The constant multipliers share one x2/x4/x8 chain, which keeps the
  // depth at three xtime levels per byte.
  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// InvMixColumns matrix applied to one 32-bit state column (row 0 in MSB byte).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input.
// Ports: col (column in), mixed_col (transformed column out).
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed_col
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  // Each output row is the coefficient row {0e,0b,0d,09} rotated right by
  // the row index.
  assign mixed_col[31:24] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
  assign mixed_col[23:16] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
  assign mixed_col[15:8]  = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
  assign mixed_col[7:0]   = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);

endmodule

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns pipeline stage over a full 128-bit state block.
// Latency: 1 cycle from v_i/block to v_o/mixed_block.
// Backpressure: none; a new block is accepted every cycle.
// Ports: clk_i, reset_i (sync, active-high), v_i/block in, v_o/mixed_block out.
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         v_i,
  input  logic [127:0] block,
  output logic         v_o,
  output logic [127:0] mixed_block
);

  state_t mix_next;

  // Column c occupies block[127-32c -: 32]; the four columns are independent.
  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_single_column u_col (
      .col       (block[127-32*c -: 32]),
      .mixed_col (mix_next[127-32*c -: 32])
    );
  end

  // The data register only loads on valid so it holds the last result while
  // the stream is idle; reset wins over an incoming valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mixed_block <= '0;
      v_o         <= 1'b0;
    end else begin
      v_o <= v_i;
      if (v_i) begin
        mixed_block <= mix_next;
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns: directed vectors plus random stream.
// Latency: expects results one cycle after acceptance.
// Backpressure: none exercised; the stage always accepts.
module tb_inv_mix_columns;

  logic         clk_i;
  logic         reset_i;
  logic         v_i;
  logic [127:0] block;
  logic         v_o;
  logic [127:0] mixed_block;

  int checks;
  int errors;

  // Reference state: what the output register should hold.
  logic         exp_v;
  logic [127:0] exp_blk;
  logic [127:0] exp_src;
  logic         exp_src_ok;

  localparam logic [31:0] INV_COEF = 32'h0e0b0d09;
  localparam logic [31:0] FWD_COEF = 32'h02030101;

  inv_mix_columns dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .block       (block),
    .v_o         (v_o),
    .mixed_block (mixed_block)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Generic shift-and-add multiply in GF(2^8) mod 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  // Circulant matrix times each column; coefs holds the first matrix row.
  function automatic logic [127:0] mat_mul(input logic [127:0] blk, input logic [31:0] coefs);
    logic [127:0] res;
    logic [7:0]   acc;
    logic [7:0]   a;
    logic [7:0]   co;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          a   = blk[127-32*c-8*k -: 8];
          co  = coefs[31-8*((k-r+4)%4) -: 8];
          acc = acc ^ gmul(co, a);
        end
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, update the reference from the inputs that were
  // sampled at that edge, then compare outputs.
  task automatic step(input string tag);
    @(posedge clk_i);
    #1;
    if (reset_i) begin
      exp_v      = 1'b0;
      exp_blk    = '0;
      exp_src_ok = 1'b0;
    end else begin
      exp_v = v_i;
      if (v_i) begin
        exp_blk    = mat_mul(block, INV_COEF);
        exp_src    = block;
        exp_src_ok = 1'b1;
      end
    end
    check_val({tag, "_v"}, {127'd0, v_o}, {127'd0, exp_v});
    check_val({tag, "_dat"}, mixed_block, exp_blk);
    if (exp_v && exp_src_ok)
      check_val({tag, "_fwd"}, mat_mul(mixed_block, FWD_COEF), exp_src);
  endtask

  logic [127:0] stream [3];
  logic [127:0] held;

  initial begin
    checks     = 0;
    errors     = 0;
    exp_v      = 1'b0;
    exp_blk    = '0;
    exp_src    = '0;
    exp_src_ok = 1'b0;

    // Reset held two cycles with a valid nonzero block present.
    reset_i = 1'b1;
    v_i     = 1'b1;
    block   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    step("rst0");
    check_val("rst0_zero", mixed_block, 128'h0);
    step("rst1");
    check_val("rst1_zero", mixed_block, 128'h0);
    check_val("rst1_vo", {127'd0, v_o}, 128'h0);

    // FIPS column vectors.
    reset_i = 1'b0;
    v_i     = 1'b1;
    block   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    step("fips1");
    check_val("fips1_const", mixed_block, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    check_val("fips1_vo", {127'd0, v_o}, 128'h1);

    block = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    step("fips2");
    check_val("fips2_const", mixed_block, 128'hd4d4d4d5_2d26314c_00000000_ffffffff);

    // Hold: invalid cycles must not disturb the previous result.
    held  = mixed_block;
    v_i   = 1'b0;
    block = 128'h0123456789abcdef_fedcba9876543210;
    step("hold0");
    check_val("hold0_keep", mixed_block, held);
    check_val("hold0_vo", {127'd0, v_o}, 128'h0);
    block = 128'hffffffff_00000000_deadbeef_12345678;
    step("hold1");
    check_val("hold1_keep", mixed_block, held);

    // Back-to-back streaming.
    stream[0] = 128'h627bceb9999d5aaac945ecf423f56da5;
    stream[1] = 128'h516604954353950314fb86e401922521;
    stream[2] = 128'h5f9c6abfbac634aa50409fa766677653;
    for (int i = 0; i < 3; i++) begin
      v_i   = 1'b1;
      block = stream[i];
      step("stream");
      check_val("stream_vo", {127'd0, v_o}, 128'h1);
      check_val("stream_inv", mat_mul(mixed_block, FWD_COEF), stream[i]);
    end
    v_i = 1'b0;
    step("stream_end");

    // Mid-stream reset drops the in-flight block.
    v_i     = 1'b1;
    block   = stream[0];
    reset_i = 1'b1;
    step("midrst");
    reset_i = 1'b0;
    block   = stream[1];
    step("postrst");
    check_val("postrst_first", mixed_block, mat_mul(stream[1], INV_COEF));

    // Random stream with occasional reset.
    for (int n = 0; n < 10000; n++) begin
      reset_i = ($urandom_range(0, 63) == 0);
      v_i     = $urandom_range(0, 3) != 0;
      block   = {$urandom, $urandom, $urandom, $urandom};
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
